// File: rtl/p405s_ocm_pkg.sv
// Shared types and constants for the instruction-side OCM responder.
package p405s_ocm_pkg;

    localparam int WAITW  = 2;   // wait-state counter width (0..3 wait states)
    localparam int OCM_AW = 14;  // default fetch address width (doubleword address)
    localparam int OCM_DW = 64;  // default fetch data width (two instructions)

    // Responder states; encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        CAP  = 3'd3,
        DV   = 3'd4
    } ocmState_t;

endpackage

// File: rtl/p405s_ocm_waitCnt.sv
// Loadable down-counter that times the extra SRAM access cycles.
module p405s_ocm_waitCnt
    import p405s_ocm_pkg::*;
(
    input  logic             CB,
    input  logic             resetCore_NEG,
    input  logic             load,
    input  logic [WAITW-1:0] loadVal,
    input  logic             dec,
    output logic [WAITW-1:0] cnt,
    output logic             zero,
    output logic             one
);

    // Load has priority over decrement; the counter never wraps below zero.
    always_ff @(posedge CB or negedge resetCore_NEG) begin
        if (!resetCore_NEG) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Flags consumed by the responder FSM.
    always_comb begin
        zero = (cnt == '0);
        one  = (cnt == WAITW'(1));
    end

endmodule

// File: rtl/p405s_ocm_icuresp.sv
// Instruction-side OCM responder: serves one ICU fetch at a time from a
// synchronous SRAM and returns registered data with a data-valid strobe.
// Handshake: a request is accepted (OCM_icuAddrAck) in any cycle where
// ICU_ocmReq is high, OCM_isHold is low and ICU_ocmAbort is low; data is
// consumed in any cycle where OCM_icuDv is high and ICU_ocmIcuReady_NEG is low.
module p405s_ocm_icuresp
    import p405s_ocm_pkg::*;
#(
    parameter int AW          = OCM_AW,
    parameter int DW          = OCM_DW,
    parameter int WAIT_STATES = 0
) (
    input  logic          CB,
    input  logic          resetCore_NEG,
    input  logic          ICU_ocmReq,
    input  logic [AW-1:0] ICU_ocmAddr,
    input  logic          ICU_ocmAbort,
    input  logic          ICU_ocmIcuReady_NEG,
    output logic          OCM_icuAddrAck,
    output logic          OCM_isHold,
    output logic          OCM_icuDv,
    output logic [DW-1:0] OCM_icuData,
    output logic          OCM_sramEn,
    output logic [AW-1:0] OCM_sramAddr,
    input  logic [DW-1:0] sram_ocmRdData,
    output logic [2:0]    dbgState
);

    localparam logic [WAITW-1:0] WAIT_LD = WAITW'(WAIT_STATES);

    ocmState_t        state;
    ocmState_t        stateNxt;
    logic [AW-1:0]    addrReg;
    logic [DW-1:0]    dataReg;
    logic             cntLoad;
    logic             cntDec;
    logic [WAITW-1:0] waitCnt;
    logic             cntZero;
    logic             cntOne;

    p405s_ocm_waitCnt uWaitCnt (
        .CB            (CB),
        .resetCore_NEG (resetCore_NEG),
        .load          (cntLoad),
        .loadVal       (WAIT_LD),
        .dec           (cntDec),
        .cnt           (waitCnt),
        .zero          (cntZero),
        .one           (cntOne)
    );

    // State register.
    always_ff @(posedge CB or negedge resetCore_NEG) begin
        if (!resetCore_NEG) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Latch the fetch address on accept; capture SRAM data in CAP.
    always_ff @(posedge CB or negedge resetCore_NEG) begin
        if (!resetCore_NEG) begin
            addrReg <= '0;
            dataReg <= '0;
        end else begin
            if (OCM_icuAddrAck) begin
                addrReg <= ICU_ocmAddr;
            end
            if (state == CAP) begin
                dataReg <= sram_ocmRdData;
            end
        end
    end

    // Next-state and output decode; abort overrides everything outside IDLE.
    always_comb begin
        stateNxt       = state;
        cntLoad        = 1'b0;
        cntDec         = 1'b0;
        OCM_sramEn     = 1'b0;
        OCM_icuDv      = 1'b0;
        OCM_isHold     = !((state == IDLE) || ((state == DV) && !ICU_ocmIcuReady_NEG));
        OCM_icuAddrAck = ICU_ocmReq && !OCM_isHold && !ICU_ocmAbort;

        case (state)
            IDLE: begin
                if (OCM_icuAddrAck) begin
                    stateNxt = RD;
                end
            end
            RD: begin
                OCM_sramEn = 1'b1;
                cntLoad    = 1'b1;
                stateNxt   = (WAIT_STATES > 0) ? WT : CAP;
            end
            WT: begin
                cntDec = 1'b1;
                // Zero is a safety exit; normal exit is the last wait cycle.
                if (cntOne || cntZero) begin
                    stateNxt = CAP;
                end
            end
            CAP: begin
                stateNxt = DV;
            end
            DV: begin
                OCM_icuDv = 1'b1;
                if (!ICU_ocmIcuReady_NEG) begin
                    stateNxt = OCM_icuAddrAck ? RD : IDLE;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        if (ICU_ocmAbort && (state != IDLE)) begin
            stateNxt  = IDLE;
            OCM_icuDv = 1'b0;
        end
    end

    // Registered datapath outputs and debug state.
    always_comb begin
        OCM_icuData  = dataReg;
        OCM_sramAddr = addrReg;
        dbgState     = state;
    end

endmodule

// File: tb/tb_p405s_ocm_icuresp.sv
// Directed bench for the OCM ICU responder: three instances with 0, 2 and 3
// wait states share clock and reset, each with its own SRAM model.
module tb_p405s_ocm_icuresp;

    logic        clk;
    logic        rstN;
    logic        req      [3];
    logic [13:0] addr     [3];
    logic        abort    [3];
    logic        rdyN     [3];
    logic        ack      [3];
    logic        hold     [3];
    logic        dv       [3];
    logic [63:0] data     [3];
    logic        sramEn   [3];
    logic [13:0] sramAddr [3];
    logic [63:0] rdData   [3];
    logic [2:0]  dbg      [3];

    int total = 0;
    int bad   = 0;

    p405s_ocm_icuresp #(.AW(14), .DW(64), .WAIT_STATES(0)) dut0 (
        .CB(clk), .resetCore_NEG(rstN), .ICU_ocmReq(req[0]), .ICU_ocmAddr(addr[0]),
        .ICU_ocmAbort(abort[0]), .ICU_ocmIcuReady_NEG(rdyN[0]), .OCM_icuAddrAck(ack[0]),
        .OCM_isHold(hold[0]), .OCM_icuDv(dv[0]), .OCM_icuData(data[0]), .OCM_sramEn(sramEn[0]),
        .OCM_sramAddr(sramAddr[0]), .sram_ocmRdData(rdData[0]), .dbgState(dbg[0]));

    p405s_ocm_icuresp #(.AW(14), .DW(64), .WAIT_STATES(2)) dut1 (
        .CB(clk), .resetCore_NEG(rstN), .ICU_ocmReq(req[1]), .ICU_ocmAddr(addr[1]),
        .ICU_ocmAbort(abort[1]), .ICU_ocmIcuReady_NEG(rdyN[1]), .OCM_icuAddrAck(ack[1]),
        .OCM_isHold(hold[1]), .OCM_icuDv(dv[1]), .OCM_icuData(data[1]), .OCM_sramEn(sramEn[1]),
        .OCM_sramAddr(sramAddr[1]), .sram_ocmRdData(rdData[1]), .dbgState(dbg[1]));

    p405s_ocm_icuresp #(.AW(14), .DW(64), .WAIT_STATES(3)) dut2 (
        .CB(clk), .resetCore_NEG(rstN), .ICU_ocmReq(req[2]), .ICU_ocmAddr(addr[2]),
        .ICU_ocmAbort(abort[2]), .ICU_ocmIcuReady_NEG(rdyN[2]), .OCM_icuAddrAck(ack[2]),
        .OCM_isHold(hold[2]), .OCM_icuDv(dv[2]), .OCM_icuData(data[2]), .OCM_sramEn(sramEn[2]),
        .OCM_sramAddr(sramAddr[2]), .sram_ocmRdData(rdData[2]), .dbgState(dbg[2]));

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM preload pattern: every word is derived from its address.
    function automatic logic [63:0] word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a, 16'hBEEF, 2'b00, a};
    endfunction

    // SRAM models: one-cycle read latency, output held between reads.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sramEn[i]) rdData[i] <= word(sramAddr[i]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = '0; abort[i] = 1'b0; rdyN[i] = 1'b0; rdData[i] = '0;
        end
        tick;
        tick;
        rstN = 1'b1;
        #1;

        // Reset state
        check("rst ack",   ack[0],      1'b0);
        check("rst hold",  hold[0],     1'b0);
        check("rst dv",    dv[0],       1'b0);
        check("rst data",  data[0],     64'h0);
        check("rst sramEn", sramEn[0],  1'b0);
        check("rst sramAddr", sramAddr[0], 14'h0);
        check("rst state", dbg[0],      3'd0);
        check("rst hold ws3", hold[2],  1'b0);

        // Test 1: zero wait states, nominal latency 3
        req[0] = 1'b1; addr[0] = 14'h0010; rdyN[0] = 1'b0; #1;
        check("t1 ack N", ack[0], 1'b1);
        tick; req[0] = 1'b0; #1;
        check("t1 sramEn N+1", sramEn[0], 1'b1);
        check("t1 sramAddr N+1", sramAddr[0], 14'h0010);
        check("t1 hold N+1", hold[0], 1'b1);
        check("t1 dv N+1", dv[0], 1'b0);
        tick; #1;
        check("t1 hold N+2", hold[0], 1'b1);
        check("t1 sramEn N+2", sramEn[0], 1'b0);
        check("t1 dv N+2", dv[0], 1'b0);
        tick; #1;
        check("t1 dv N+3", dv[0], 1'b1);
        check("t1 data N+3", data[0], word(14'h0010));
        check("t1 hold N+3", hold[0], 1'b0);
        tick; #1;
        check("t1 dv after", dv[0], 1'b0);
        check("t1 idle", dbg[0], 3'd0);

        // Test 3: ICU not ready for 4 cycles in DV
        req[0] = 1'b1; addr[0] = 14'h0030; rdyN[0] = 1'b1; #1;
        check("t3 ack", ack[0], 1'b1);
        tick; req[0] = 1'b0; #1;
        tick; #1;
        for (int k = 0; k < 4; k++) begin
            tick; #1;
            check("t3 dv stall", dv[0], 1'b1);
            check("t3 data stall", data[0], word(14'h0030));
            check("t3 hold stall", hold[0], 1'b1);
        end
        rdyN[0] = 1'b0; #1;
        check("t3 hold consume", hold[0], 1'b0);
        check("t3 dv consume", dv[0], 1'b1);
        tick; #1;
        check("t3 dv after", dv[0], 1'b0);
        check("t3 idle", dbg[0], 3'd0);

        // Test 4: back-to-back, second ack in the consume cycle
        req[0] = 1'b1; addr[0] = 14'h0010; #1;
        check("t4 ack1", ack[0], 1'b1);
        tick; addr[0] = 14'h0020; #1;
        check("t4 no ack RD", ack[0], 1'b0);
        tick; #1;
        check("t4 no ack CAP", ack[0], 1'b0);
        tick; #1;
        check("t4 dv1", dv[0], 1'b1);
        check("t4 data1", data[0], word(14'h0010));
        check("t4 ack2", ack[0], 1'b1);
        tick; req[0] = 1'b0; #1;
        check("t4 RD2 state", dbg[0], 3'd1);
        check("t4 sramAddr2", sramAddr[0], 14'h0020);
        check("t4 dv gap", dv[0], 1'b0);
        tick; #1;
        check("t4 dv gap2", dv[0], 1'b0);
        tick; #1;
        check("t4 dv2", dv[0], 1'b1);
        check("t4 data2", data[0], word(14'h0020));
        tick; #1;
        check("t4 idle", dbg[0], 3'd0);

        // Test 2: two wait states, Dv at N+5
        req[1] = 1'b1; addr[1] = 14'h0010; rdyN[1] = 1'b0; #1;
        check("t2 ack", ack[1], 1'b1);
        tick; req[1] = 1'b0; #1;
        check("t2 sramEn N+1", sramEn[1], 1'b1);
        check("t2 sramAddr N+1", sramAddr[1], 14'h0010);
        for (int k = 2; k <= 4; k++) begin
            tick; #1;
            check("t2 dv early", dv[1], 1'b0);
            check("t2 hold busy", hold[1], 1'b1);
        end
        tick; #1;
        check("t2 dv N+5", dv[1], 1'b1);
        check("t2 data N+5", data[1], word(14'h0010));
        tick; #1;
        check("t2 idle", dbg[1], 3'd0);

        // Test 5: abort in WT with coincident request
        req[2] = 1'b1; addr[2] = 14'h0040; rdyN[2] = 1'b0; #1;
        check("t5 ack", ack[2], 1'b1);
        tick; req[2] = 1'b0; #1;
        tick; #1;
        check("t5 in WT", dbg[2], 3'd2);
        abort[2] = 1'b1; req[2] = 1'b1; addr[2] = 14'h0044; #1;
        check("t5 abort no ack", ack[2], 1'b0);
        tick; abort[2] = 1'b0; req[2] = 1'b0; #1;
        check("t5 idle after abort", dbg[2], 3'd0);
        check("t5 hold after abort", hold[2], 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick; #1;
            check("t5 no dv", dv[2], 1'b0);
        end
        req[2] = 1'b1; addr[2] = 14'h0048; #1;
        check("t5 ack next", ack[2], 1'b1);
        tick; req[2] = 1'b0; #1;
        check("t5 sramAddr next", sramAddr[2], 14'h0048);
        for (int k = 2; k <= 5; k++) begin
            tick; #1;
            check("t5 dv early", dv[2], 1'b0);
        end
        tick; #1;
        check("t5 dv N+6", dv[2], 1'b1);
        check("t5 data N+6", data[2], word(14'h0048));
        tick; #1;

        // Test 6: asynchronous reset during CAP
        req[0] = 1'b1; addr[0] = 14'h0050; #1;
        check("t6 ack", ack[0], 1'b1);
        tick; req[0] = 1'b0; #1;
        tick; #1;
        check("t6 in CAP", dbg[0], 3'd3);
        rstN = 1'b0; #1;
        check("t6 rst state", dbg[0], 3'd0);
        check("t6 rst hold", hold[0], 1'b0);
        check("t6 rst dv", dv[0], 1'b0);
        check("t6 rst data", data[0], 64'h0);
        check("t6 rst sramAddr", sramAddr[0], 14'h0);
        tick;
        rstN = 1'b1; #1;
        check("t6 post dv", dv[0], 1'b0);
        req[0] = 1'b1; addr[0] = 14'h0060; #1;
        check("t6 post ack", ack[0], 1'b1);
        tick; req[0] = 1'b0; #1;
        check("t6 post sramEn", sramEn[0], 1'b1);
        tick; #1;
        check("t6 post dv N+2", dv[0], 1'b0);
        tick; #1;
        check("t6 post dv N+3", dv[0], 1'b1);
        check("t6 post data", data[0], word(14'h0060));
        tick; #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
